// File: rtl/de2_115_sopc_cpu_mul_pkg.sv
// Shared definitions for the sequential 32x32 multiplier.
// Holds the op encodings, the controller state enum, the response latency
// constants and small helpers for the partial-product schedule.
package de2_115_sopc_cpu_mul_pkg;

  typedef enum logic [1:0] {
    OpMul    = 2'b00,  // low 32 bits of the product
    OpMulxuu = 2'b01,  // high 32, both operands unsigned
    OpMulxsu = 2'b10,  // high 32, src1 signed, src2 unsigned
    OpMulxss = 2'b11   // high 32, both operands signed
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StAcc,
    StFix,
    StDone
  } state_e;

  // Edges from accept to rsp_valid high.
  localparam int unsigned LAT_MUL  = 4;
  localparam int unsigned LAT_MULX = 6;

  // Partial index: 0 = al*bl, 1 = ah*bl, 2 = al*bh, 3 = ah*bh.
  function automatic logic [5:0] partial_shift(input logic [1:0] idx);
    case (idx)
      2'd0:    partial_shift = 6'd0;
      2'd1,
      2'd2:    partial_shift = 6'd16;
      default: partial_shift = 6'd32;
    endcase
  endfunction

  // MUL never needs ah*bh: it only contributes above bit 31.
  function automatic logic [1:0] last_idx(input op_e op);
    last_idx = (op == OpMul) ? 2'd2 : 2'd3;
  endfunction

endpackage

// File: rtl/de2_115_sopc_cpu_mul_seq_cell.sv
// Shared 16x16 unsigned multiplier cell with a single product register.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high clear
//   i_en       : load a new product this cycle
//   i_a, i_b   : 16-bit unsigned operands
//   o_prod     : registered 32-bit product, valid one cycle after i_en
module de2_115_sopc_cpu_mul_seq_cell (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_prod
);

  logic [31:0] r_prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prod <= 32'd0;
    end else if (i_en) begin
      r_prod <= 32'(i_a) * 32'(i_b);
    end
  end

  assign o_prod = r_prod;

endmodule

// File: rtl/de2_115_sopc_cpu_mul_seq.sv
// Sequential 32x32 multiplier built from one shared 16x16 cell.
// Partials are issued one per cycle and summed into a 64-bit accumulator;
// MULX ops get a signed correction of the high word before the result is
// presented.
// Ports:
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake (ready only in IDLE)
//   req_op               : 00 MUL, 01 MULXUU, 10 MULXSU, 11 MULXSS
//   req_src1, req_src2   : 32-bit operands
//   rsp_valid/rsp_ready  : response handshake
//   rsp_data             : result word, held until the next result
//   busy                 : high whenever not IDLE
module de2_115_sopc_cpu_mul_seq
  import de2_115_sopc_cpu_mul_pkg::*;
#(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy
);

  // Accumulation trails issue by the cell latency.
  localparam logic [1:0] AccSkew = 2'(MUL_LAT);

  state_e      r_state;
  state_e      w_state_next;
  op_e         r_op;
  logic [31:0] r_src1;
  logic [31:0] r_src2;
  logic [1:0]  r_idx;   // next partial to issue
  logic [1:0]  r_pidx;  // partial currently held in the cell
  logic [63:0] r_acc;
  logic [31:0] r_rsp_data;

  logic        w_accept;
  logic        w_issue;
  logic        w_acc_en;
  logic        w_load_rsp;
  logic [31:0] w_rsp_next;
  logic [15:0] w_cell_a;
  logic [15:0] w_cell_b;
  logic [31:0] w_prod;
  logic [63:0] w_addend;
  logic [63:0] w_acc_sum;
  logic [31:0] w_fix_hi;

  assign w_accept  = (r_state == StIdle) && req_valid;
  assign w_addend  = {32'd0, w_prod} << partial_shift(r_pidx);
  assign w_acc_sum = r_acc + w_addend;

  always_comb begin
    w_cell_a = r_src1[15:0];
    w_cell_b = r_src2[15:0];
    case (r_idx)
      2'd0: begin w_cell_a = r_src1[15:0];  w_cell_b = r_src2[15:0];  end
      2'd1: begin w_cell_a = r_src1[31:16]; w_cell_b = r_src2[15:0];  end
      2'd2: begin w_cell_a = r_src1[15:0];  w_cell_b = r_src2[31:16]; end
      default: begin w_cell_a = r_src1[31:16]; w_cell_b = r_src2[31:16]; end
    endcase
  end

  de2_115_sopc_cpu_mul_seq_cell u_cell (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_issue),
    .i_a    (w_cell_a),
    .i_b    (w_cell_b),
    .o_prod (w_prod)
  );

  // Unsigned high word minus the other operand for each negative signed one.
  always_comb begin
    w_fix_hi = r_acc[63:32];
    if ((r_op == OpMulxsu || r_op == OpMulxss) && r_src1[31]) begin
      w_fix_hi = w_fix_hi - r_src2;
    end
    if (r_op == OpMulxss && r_src2[31]) begin
      w_fix_hi = w_fix_hi - r_src1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_acc_en     = 1'b0;
    w_load_rsp   = 1'b0;
    w_rsp_next   = r_rsp_data;
    case (r_state)
      StIdle: begin
        if (req_valid) w_state_next = StIssue;
      end
      StIssue: begin
        w_issue  = 1'b1;
        w_acc_en = (r_idx >= AccSkew);
        if (r_idx == last_idx(r_op)) w_state_next = StAcc;
      end
      StAcc: begin
        w_acc_en = 1'b1;
        if (r_op == OpMul) begin
          w_state_next = StDone;
          w_load_rsp   = 1'b1;
          w_rsp_next   = w_acc_sum[31:0];
        end else begin
          w_state_next = StFix;
        end
      end
      StFix: begin
        w_state_next = StDone;
        w_load_rsp   = 1'b1;
        w_rsp_next   = w_fix_hi;
      end
      StDone: begin
        // Returning to IDLE first keeps a new request out of this cycle.
        if (rsp_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_op       <= OpMul;
      r_src1     <= 32'd0;
      r_src2     <= 32'd0;
      r_idx      <= 2'd0;
      r_pidx     <= 2'd0;
      r_acc      <= 64'd0;
      r_rsp_data <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op   <= op_e'(req_op);
        r_src1 <= req_src1;
        r_src2 <= req_src2;
        r_idx  <= 2'd0;
        r_acc  <= 64'd0;
      end
      if (w_issue) begin
        r_idx  <= r_idx + 2'd1;
        r_pidx <= r_idx;
      end
      if (w_acc_en)   r_acc      <= w_acc_sum;
      if (w_load_rsp) r_rsp_data <= w_rsp_next;
    end
  end

  assign req_ready = (r_state == StIdle);
  assign rsp_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_de2_115_sopc_cpu_mul_seq.sv
module tb_de2_115_sopc_cpu_mul_seq;

  localparam int ExpLatMul  = 4;
  localparam int ExpLatMulx = 6;
  localparam int WaitLimit  = 20;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;

  int n_checks;
  int n_fail;

  de2_115_sopc_cpu_mul_seq #(
    .MUL_LAT (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  // Reference: full 64-bit product of the sign/zero-extended operands.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (op == 2'b10 || op == 2'b11) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == 2'b11) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_lat(input logic [1:0] op);
    return (op == 2'b00) ? ExpLatMul : ExpLatMulx;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Call with the DUT in IDLE, just after a rising edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] data, output int lat);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_src1  = $urandom;
    req_src2  = $urandom;
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (!rsp_valid && lat < WaitLimit) begin
      @(posedge clk);
      #1;
      lat++;
    end
    data = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_data", rsp_data, data);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_hs_req_ready", 32'(req_ready), 32'd1);
  endtask

  vec_t        vecs[8];
  logic [31:0] data;
  logic [31:0] held;
  logic [31:0] cand[5];
  int          lat;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_src1  = 32'd0;
    req_src2  = 32'd0;
    rsp_ready = 1'b0;

    vecs[0] = '{2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4] = '{2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[5] = '{2'b11, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[6] = '{2'b11, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);

    // Directed vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, data, lat);
      check($sformatf("vec%0d_data", i), data, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(exp_lat(vecs[i].op)));
    end

    // Backpressure with a competing request
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_src1  = 32'd9;
    req_src2  = 32'd11;
    @(posedge clk);
    #1;
    req_src1 = 32'd1000;
    req_src2 = 32'd1000;
    lat = 0;
    while (!rsp_valid && lat < WaitLimit) begin
      @(posedge clk);
      #1;
      lat++;
    end
    held = rsp_data;
    check("bp_data", held, 32'd99);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data", rsp_data, held);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("bp_no_accept_in_hs_ready", 32'(req_ready), 32'd1);
    check("bp_no_accept_in_hs_busy", 32'(busy), 32'd0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;

    // Reset two cycles after accept
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_src1  = 32'h1234_5678;
    req_src2  = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp_data", rsp_data, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    run_op(2'b00, 32'd7, 32'd6, 0, data, lat);
    check("midrst_next_mul", data, 32'd42);

    // Randomized ops against the model
    cand = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? cand[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? cand[$urandom_range(0, 4)] : $urandom;
      run_op(op, a, b, $urandom_range(0, 3), data, lat);
      check($sformatf("rand%0d_op%0d_data", i, op), data, model(op, a, b));
      check($sformatf("rand%0d_lat", i), 32'(lat), 32'(exp_lat(op)));
    end

    // Streaming, alternating MUL / MULXUU
    begin
      logic [31:0] expq[$];
      logic [1:0]  opq[$];
      logic [1:0]  prev_op;
      int          edge_no;
      int          prev_edge;
      int          n_acc;
      int          budget;
      logic        fire_req;
      logic        fire_rsp;
      logic [31:0] snap;
      edge_no   = 0;
      prev_edge = -1;
      prev_op   = 2'b00;
      n_acc     = 0;
      budget    = 0;
      req_op    = 2'b00;
      req_src1  = $urandom;
      req_src2  = $urandom;
      req_valid = 1'b1;
      rsp_ready = 1'b1;
      while ((n_acc < 8 || expq.size() != 0) && budget < 200) begin
        fire_req = req_valid && req_ready;
        fire_rsp = rsp_valid && rsp_ready;
        snap     = rsp_data;
        if (fire_rsp) begin
          if (expq.size() == 0) begin
            check("stream_unexpected_rsp", 32'(rsp_valid), 32'd0);
          end else begin
            check($sformatf("stream_op%0d_data", opq.pop_front()), snap, expq.pop_front());
          end
        end
        if (fire_req) begin
          expq.push_back(model(req_op, req_src1, req_src2));
          opq.push_back(req_op);
        end
        @(posedge clk);
        #1;
        edge_no++;
        budget++;
        if (fire_req) begin
          if (prev_edge >= 0) begin
            check("stream_gap", 32'(edge_no - prev_edge),
                  (prev_op == 2'b00) ? 32'd6 : 32'd8);
          end
          prev_edge = edge_no;
          prev_op   = req_op;
          n_acc++;
          req_op   = (req_op == 2'b00) ? 2'b01 : 2'b00;
          req_src1 = $urandom;
          req_src2 = $urandom;
          if (n_acc >= 8) req_valid = 1'b0;
        end
      end
      check("stream_drained", 32'(expq.size()), 32'd0);
      check("stream_count", 32'(n_acc), 32'd8);
      rsp_ready = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/de2_115_sopc_cpu_mul_seq.md
DE2_115_SOPC_CPU_MUL_SEQ -- requirements
Module: DE2_115_SOPC_cpu_mul_seq

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 The block SHALL have parameter: MUL_LAT, 1, register latency of the shared 16x16 cell; only the value 1 is supported.
REQ-003 The block SHALL have port: clk  in  1  rising-edge clock.
REQ-004 The block SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port: req_valid  in  1  request present.
REQ-006 The block SHALL have port: req_ready  out  1  request accepted when req_valid&req_ready at an edge.
REQ-007 The block SHALL have port: req_op  in  2  00 MUL (low 32), 01 MULXUU, 10 MULXSU (src1 signed, src2 unsigned), 11 MULXSS (high 32 for the three MULX ops).
REQ-008 The block SHALL have ports: req_src1 and req_src2, each  in  32  operands.
REQ-009 The block SHALL have port: rsp_valid  out  1  result available.
REQ-010 The block SHALL have port: rsp_ready  in  1  result consumed when rsp_valid&rsp_ready at an edge.
REQ-011 The block SHALL have port: rsp_data  out  32  result word.
REQ-012 The block SHALL have port: busy  out  1  high in every state except IDLE.

Function
REQ-013 States SHALL be IDLE, ISSUE, ACC, FIX and DONE; req_ready SHALL equal (state==IDLE).
REQ-014 On accept, operands and op SHALL be registered and the block SHALL enter ISSUE; inputs SHALL then be ignored until IDLE.
REQ-015 Issue order into the shared cell SHALL be one partial per cycle: al*bl, ah*bl, al*bh, ah*bh; MUL SHALL skip ah*bh.
REQ-016 Each partial SHALL be added into a 64-bit unsigned accumulator one cycle after issue, shifted left by 0, 16, 16 and 32 bits respectively, with no overflow truncation below bit 64.
REQ-017 FIX (MULX ops only) SHALL subtract src2 from the high word when src1 is signed-negative, and src1 when src2 is signed-negative (MULXSS both, MULXSU src1 only, MULXUU none), modulo 2^32.
REQ-018 After an accept at edge N, rsp_valid SHALL rise after edge N+4 for MUL and after edge N+6 for MULX ops.
REQ-019 rsp_valid and rsp_data SHALL be held stable in DONE until a handshake with rsp_ready; the state SHALL then return to IDLE; a new request SHALL NOT be accepted in the handshake cycle.
REQ-020 When rsp_valid is low, rsp_data SHALL retain its last value; op encoding 11 with zero operands SHALL yield 0 with no special casing.

Reset
REQ-021 While reset is high at an edge, the state SHALL go to IDLE and the accumulator, rsp_data and rsp_valid SHALL clear to 0; busy SHALL be 0 and req_ready SHALL be 1 after the edge.
REQ-022 Reset mid-operation SHALL discard the operation with no response emitted, including any partial in flight in the cell.
REQ-023 Reset SHALL take priority over all simultaneous handshakes.

Structure
REQ-024 Package DE2_115_SOPC_cpu_mul_pkg SHALL hold the op encodings, the state enum, and the latency constants (LAT_MUL=4, LAT_MULX=6).
REQ-025 Sub-module DE2_115_SOPC_cpu_mul_seq_cell SHALL be a 16x16 unsigned multiplier with a 32-bit result, one product register, and a synchronous clear on reset; it SHALL be instantiated once.

Verification
REQ-026 MUL: 0x00010003 * 0x00020005 -> rsp_data 0x000B000F, rsp_valid after edge N+4.
REQ-027 MULXUU: 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE after edge N+6; MULXSS on the same operands -> 0x00000000; MULXSU -> 0xFFFFFFFF.
REQ-028 MULXSS: 0x80000000 * 0x80000000 -> 0x40000000; 0x80000000 * 0x00000001 -> 0xFFFFFFFF.
REQ-029 Backpressure: hold rsp_ready low 3 cycles -> rsp_data stable, req_ready 0, and a concurrent req_valid is not accepted.
REQ-030 Reset pulse 2 cycles after accept -> no rsp_valid, req_ready=1; the next MUL 7*6 returns 42.
REQ-031 Streaming: hold req_valid and rsp_ready high with alternating MUL/MULXUU -> accepts spaced 6 and 8 edges apart, all results match the reference model.
